// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, S-box tables and state enum
// Shared with the round controller and key expansion.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sbox_state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_byte.sv
// rtl/sbox_byte.sv - single-byte AES S-box / inverse S-box lookup
// Purely combinational; the inverse table is only built when INVERSE_EN=1.
module sbox_byte
  import aes_pkg::*;
#(
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  if (INVERSE_EN) begin : g_both
    assign out = inv ? SBOX_INV[in] : SBOX_FWD[in];
  end else begin : g_fwd
    logic unused_inv;
    assign unused_inv = inv;
    assign out = SBOX_FWD[in];
  end

endmodule

// File: rtl/sbox_iter_unit.sv
// rtl/sbox_iter_unit.sv - iterative handshaked (Inv)SubBytes over LANES bytes per cycle
// FSM, byte-group counter, working register and lane mux/demux.
module sbox_iter_unit
  import aes_pkg::*;
#(
  parameter int LANES      = 4,
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int GROUPS = AES_NB_BYTES / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LG     = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sbox_iter_unit: LANES must be 1, 2, 4, 8 or 16");
  end

  sbox_state_e   state;
  logic [CW-1:0] cnt;
  logic          mode;
  logic [7:0]    work      [AES_NB_BYTES];
  logic [7:0]    next_work [AES_NB_BYTES];
  logic [7:0]    in_bytes  [AES_NB_BYTES];
  logic [7:0]    sub       [LANES];
  logic [127:0]  next_flat;
  logic [3:0]    base;

  // First byte of the group handled this cycle; always a multiple of LANES.
  assign base = 4'(cnt) << LG;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_byte #(.INVERSE_EN(INVERSE_EN)) u_sbox (
      .in (work[base + 4'(l)]),
      .inv(mode),
      .out(sub[l])
    );
  end

  always_comb begin
    next_work = work;
    for (int l = 0; l < LANES; l++) begin
      next_work[base + 4'(l)] = sub[l];
    end
    next_flat = '0;
    for (int i = 0; i < AES_NB_BYTES; i++) begin
      next_flat[127 - 8*i -: 8] = next_work[i];
      in_bytes[i] = in_data[127 - 8*i -: 8];
    end
  end

  assign in_ready = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      work      <= '{default: 8'h00};
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work  <= in_bytes;
            mode  <= INVERSE_EN & in_inv;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          work <= next_work;
          cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
          if (cnt == LAST) begin
            out_data  <= next_flat;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A new block may be taken in the same cycle the result leaves.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= in_bytes;
              mode  <= INVERSE_EN & in_inv;
              cnt   <= '0;
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_iter_unit.sv
// tb/tb_sbox_iter_unit.sv - self-checking bench for sbox_iter_unit
// Six instances (LANES 1/2/4/8/16 with inverse, LANES 2 forward-only) against a GF(2^8) S-box model.
module tb_sbox_iter_unit;

  localparam int NI = 6;

  function automatic int lanes_of(int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      4: return 16;
      default: return 2;
    endcase
  endfunction

  function automatic bit inv_of(int k);
    return (k == 5) ? 1'b0 : 1'b1;
  endfunction

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] in_data   [NI];
  logic         in_inv    [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_data  [NI];
  logic         busy      [NI];
  logic         acc       [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sbox_iter_unit #(.LANES(lanes_of(g)), .INVERSE_EN(inv_of(g))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_inv   (in_inv[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int popped [NI];
  logic [127:0] sbq [NI][$];
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model(logic [127:0] d, logic inv);
    logic [127:0] r = '0;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = d[127 - 8*i -: 8];
      r[127 - 8*i -: 8] = inv ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at negedge+1 with inputs set; observes handshakes, then advances one clock.
  task automatic clk_step();
    #1;
    for (int k = 0; k < NI; k++) begin
      acc[k] = 1'b0;
      if (out_valid[k] && out_ready[k]) begin
        popped[k]++;
        if (sbq[k].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected[%0d]: got %h expected nothing", k, out_data[k]);
        end else begin
          chk($sformatf("sb_data[%0d]", k), out_data[k], sbq[k].pop_front());
        end
      end
      if (in_valid[k] && in_ready[k]) begin
        sbq[k].push_back(model(in_data[k], in_inv[k] && inv_of(k)));
        acc[k] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(string name, int k, logic [127:0] data, logic inv,
                         logic [127:0] exp, int lat);
    int n = 0;
    out_ready[k] = 1'b1;
    in_valid[k]  = 1'b1;
    in_data[k]   = data;
    in_inv[k]    = inv;
    clk_step();
    chk({name, "_accept"}, 128'(acc[k]), 128'(1));
    in_valid[k] = 1'b0;
    while (!out_valid[k] && n < 40) begin
      clk_step();
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'(lat));
    chk({name, "_data"}, out_data[k], exp);
    clk_step();
  endtask

  typedef struct {
    string        name;
    int           k;
    logic [127:0] data;
    logic         inv;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [7:0] iv;
    logic [127:0] a_blk, b_blk, exp_a;
    int n, rem_total, got_total, cyc;
    int rem [NI];
    int base_pop [NI];
    bit active;

    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      end
      fwd_tab[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_inv[k] = 1'b0;
      out_ready[k] = 1'b0; acc[k] = 1'b0; popped[k] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), 128'(in_ready[k]), 128'(1));
      chk($sformatf("rst_out_valid[%0d]", k), 128'(out_valid[k]), 128'(0));
      chk($sformatf("rst_out_data[%0d]", k), out_data[k], 128'h0);
      chk($sformatf("rst_busy[%0d]", k), 128'(busy[k]), 128'(0));
    end
    rst_n = 1'b1;

    vecs.push_back('{"fwd_l4", 2, 128'h3243f6a8885a308d313198a2e0370734, 1'b0,
                     128'h231a42c2c4be045dc7c7463ae19ac518, 4});
    vecs.push_back('{"fwd_l8", 3, 128'h3243f6a8885a308d313198a2e0370734, 1'b0,
                     128'h231a42c2c4be045dc7c7463ae19ac518, 2});
    vecs.push_back('{"inv_l2", 1, 128'h231a42c2c4be045dc7c7463ae19ac518, 1'b1,
                     128'h3243f6a8885a308d313198a2e0370734, 8});
    vecs.push_back('{"noinv_l2", 5, 128'h231a42c2c4be045dc7c7463ae19ac518, 1'b1,
                     model(128'h231a42c2c4be045dc7c7463ae19ac518, 1'b0), 8});
    vecs.push_back('{"zero_l16", 4, {16{8'h00}}, 1'b0, {16{8'h63}}, 1});
    vecs.push_back('{"ff_l16", 4, {16{8'hff}}, 1'b0, {16{8'h16}}, 1});
    vecs.push_back('{"inv63_l16", 4, {16{8'h63}}, 1'b1, {16{8'h00}}, 1});
    vecs.push_back('{"zero_l1", 0, {16{8'h00}}, 1'b0, {16{8'h63}}, 16});
    vecs.push_back('{"ff_l1", 0, {16{8'hff}}, 1'b0, {16{8'h16}}, 16});
    vecs.push_back('{"inv63_l1", 0, {16{8'h63}}, 1'b1, {16{8'h00}}, 16});
    foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].k, vecs[i].data, vecs[i].inv,
                              vecs[i].exp, vecs[i].lat);

    // Backpressure on the LANES=4 instance.
    a_blk = 128'h3243f6a8885a308d313198a2e0370734;
    b_blk = 128'h00112233445566778899aabbccddeeff;
    exp_a = model(a_blk, 1'b1);
    out_ready[2] = 1'b0;
    in_valid[2] = 1'b1; in_data[2] = a_blk; in_inv[2] = 1'b1;
    clk_step();
    in_valid[2] = 1'b0;
    n = 0;
    while (!out_valid[2] && n < 40) begin clk_step(); n++; end
    chk("bp_latency", 128'(n), 128'(4));
    in_valid[2] = 1'b1; in_data[2] = b_blk; in_inv[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(out_valid[2]), 128'(1));
      chk("bp_out_data", out_data[2], exp_a);
      chk("bp_in_ready", 128'(in_ready[2]), 128'(0));
      clk_step();
      chk("bp_no_accept", 128'(acc[2]), 128'(0));
    end
    base_pop[2] = popped[2];
    out_ready[2] = 1'b1;
    clk_step();
    chk("bp_b2b_accept", 128'(acc[2]), 128'(1));
    chk("bp_b2b_pop", 128'(popped[2] - base_pop[2]), 128'(1));
    chk("bp_valid_drop", 128'(out_valid[2]), 128'(0));
    chk("bp_busy", 128'(busy[2]), 128'(1));
    in_valid[2] = 1'b0;
    n = 0;
    while (!out_valid[2] && n < 40) begin clk_step(); n++; end
    chk("bp_b_data", out_data[2], model(b_blk, 1'b0));
    clk_step();

    // Asynchronous reset after 7 of 16 groups on the LANES=1 instance.
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = 128'hdeadbeef0123456789abcdeffedcba98; in_inv[0] = 1'b0;
    clk_step();
    in_valid[0] = 1'b0;
    repeat (7) clk_step();
    chk("mid_busy", 128'(busy[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("mid_rst_out_data", out_data[0], 128'h0);
    chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    chk("mid_rst_busy", 128'(busy[0]), 128'(0));
    sbq[0].delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    run_vec("post_rst_l1", 0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
            model(128'h000102030405060708090a0b0c0d0e0f, 1'b0), 16);

    // Random regression over all instances in one process.
    rem_total = 0;
    for (int k = 0; k < NI; k++) begin
      rem[k] = (k < 4) ? 167 : 166;
      rem_total += rem[k];
      base_pop[k] = popped[k];
    end
    cyc = 0;
    active = 1'b1;
    while (active && cyc < 60000) begin
      for (int k = 0; k < NI; k++) begin
        out_ready[k] = ($urandom_range(0, 3) != 0);
        if (!in_valid[k] && rem[k] > 0 && $urandom_range(0, 2) != 0) begin
          in_valid[k] = 1'b1;
          in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
          in_inv[k]   = 1'($urandom_range(0, 1));
          rem[k]--;
        end
      end
      clk_step();
      cyc++;
      active = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (acc[k]) in_valid[k] = 1'b0;
        if (rem[k] > 0 || in_valid[k] || sbq[k].size() != 0) active = 1'b1;
      end
    end
    if (active) begin
      tests++;
      fails++;
      $display("FAIL rand_timeout: got %0d cycles expected completion", cyc);
    end
    got_total = 0;
    for (int k = 0; k < NI; k++) begin
      got_total += popped[k] - base_pop[k];
      chk($sformatf("rand_queue_empty[%0d]", k), 128'(sbq[k].size()), 128'(0));
    end
    chk("rand_count", 128'(got_total), 128'(rem_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
